// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: default widths,
// sequencer state encoding and a saturating increment helper.
package hazard_pkg;

  localparam int RA_W_DEF  = 5;
  localparam int CNT_W_DEF = 16;

  // Outstanding-fetch sequencer states.
  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_FETCH_WAIT = 2'd1;
  localparam logic [1:0] ST_DISCARD    = 2'd2;

  // Increments v unless it already equals max_v, so counters stick at the top.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Pure comparator: flags a load in EX whose destination is read by the
// instruction in ID. Register 0 is hard-wired zero and never creates a hazard.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  output logic            load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves data-memory
// wait, taken branch, load-use and instruction-fetch wait with fixed priority,
// tracks whether an in-flight fetch was made stale by a branch, and keeps
// saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_flush,
  output logic             ex_mem_write_en,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       load_use;
  logic       dstall;
  logic       fetch_stall;
  logic       branch_fire;

  load_use_detect #(.RA_W(RA_W)) u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign dstall      = mem_req && !dmem_ready;
  // Every DISCARD cycle blocks fetch: either still waiting, or dropping the stale word.
  assign fetch_stall = (state == ST_DISCARD) || !imem_ready;

  // Priority mux for the pipeline register controls (zero-latency from inputs and state).
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    pc_write        = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_write_en  = 1'b1;
    id_ex_flush     = 1'b0;
    ex_mem_write_en = 1'b1;
    mem_wb_flush    = 1'b0;
    branch_fire     = 1'b0;
    if (reset) begin
      pc_write        = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
    end else if (dstall) begin
      // EX is frozen, so a branch or load-use there is re-presented next cycle.
      pc_write        = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_flush    = 1'b1;
    end else if (ex_branch_taken) begin
      // The load-use consumer, if any, is in ID and is flushed here anyway.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      branch_fire = 1'b1;
    end else if (load_use) begin
      // Holding IF/ID takes precedence over a concurrent fetch-stall flush.
      pc_write       = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end else if (fetch_stall) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Outstanding-fetch sequencer; a data-memory stall freezes it.
  always_comb begin
    state_nxt = state;
    if (!dstall) begin
      case (state)
        ST_RUN: begin
          if (!imem_ready && !ex_branch_taken) state_nxt = ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          if (ex_branch_taken && !imem_ready) state_nxt = ST_DISCARD;
          else if (imem_ready)                state_nxt = ST_RUN;
        end
        ST_DISCARD: begin
          // A new branch leaves yet another stale fetch outstanding.
          if (imem_ready && !ex_branch_taken) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    if (reset) begin
      state        <= ST_RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_write)
        stall_cycles <= CNT_W'(sat_inc(32'(stall_cycles), 32'(CNT_MAX)));
      if (branch_fire)
        flush_count <= CNT_W'(sat_inc(32'(flush_count), 32'(CNT_MAX)));
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Control outputs are packed as
// {pc_write, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
//  ex_mem_write_en, mem_wb_flush} and compared against hand-derived patterns.
module tb_pipeline_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 16;

  localparam logic [6:0] C_RESET  = 7'b000_0000;
  localparam logic [6:0] C_IDLE   = 7'b110_1010;
  localparam logic [6:0] C_LDUSE  = 7'b000_1110;
  localparam logic [6:0] C_BRANCH = 7'b111_1110;
  localparam logic [6:0] C_FETCH  = 7'b011_1010;
  localparam logic [6:0] C_DSTALL = 7'b000_0001;

  logic             clk = 1'b0;
  logic             reset;
  logic [RA_W-1:0]  id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic             imem_ready, mem_req, dmem_ready;
  logic             pc_write, if_id_write_en, if_id_flush, id_ex_write_en;
  logic             id_ex_flush, ex_mem_write_en, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       ctrl;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_stall    = 0;
  int exp_flush    = 0;

  assign ctrl = {pc_write, if_id_write_en, if_id_flush, id_ex_write_en,
                 id_ex_flush, ex_mem_write_en, mem_wb_flush};

  pipeline_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write_en  (if_id_write_en),
    .if_id_flush     (if_id_flush),
    .id_ex_write_en  (id_ex_write_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write_en (ex_mem_write_en),
    .mem_wb_flush    (mem_wb_flush),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    ex_branch_taken = 1'b1;
    imem_ready = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_RESET) begin
      tests_failed++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RESET);
    end
    tick(); tick();
    tests_run++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      tests_failed++; $display("FAIL reset_counters got stall=%0d flush=%0d exp 0/0", stall_cycles, flush_count);
    end
    reset = 1'b0;
    set_idle();
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL idle_ctrl got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    // rs2 match: one bubble, then the load has moved on.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_LDUSE) begin
      tests_failed++; $display("FAIL t1_bubble got=%b exp=%b", ctrl, C_LDUSE);
    end
    tick(); exp_stall++;
    set_idle();
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL t1_release got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
    tests_run++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      tests_failed++; $display("FAIL t1_stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    // rs1 match.
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_LDUSE) begin
      tests_failed++; $display("FAIL lu_rs1 got=%b exp=%b", ctrl, C_LDUSE);
    end
    tick(); exp_stall++;
    // Same register but not actually read: no hazard.
    id_use_rs1 = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL lu_unused got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
    // Load-use together with a fetch wait: IF/ID hold wins, no IF/ID flush.
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; imem_ready = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_LDUSE) begin
      tests_failed++; $display("FAIL lu_fetch got=%b exp=%b", ctrl, C_LDUSE);
    end
    tick(); exp_stall++;
    // Now in FETCH_WAIT; the word arrives, so nothing stalls.
    set_idle();
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL fw_ready got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
    tests_run++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      tests_failed++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_rd_zero();
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL t2_rd_zero got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
    tests_run++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      tests_failed++; $display("FAIL t2_stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    set_idle();
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_BRANCH) begin
      tests_failed++; $display("FAIL t3_branch got=%b exp=%b", ctrl, C_BRANCH);
    end
    tick(); exp_flush++;
    tests_run++;
    if (flush_count !== CNT_W'(exp_flush)) begin
      tests_failed++; $display("FAIL t3_flush_cnt got=%0d exp=%0d", flush_count, exp_flush);
    end
    // Branch together with load-use: branch only.
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_BRANCH) begin
      tests_failed++; $display("FAIL br_lu got=%b exp=%b", ctrl, C_BRANCH);
    end
    tick(); exp_flush++;
    set_idle();
    tick();
    tests_run++;
    if (flush_count !== CNT_W'(exp_flush) || stall_cycles !== CNT_W'(exp_stall)) begin
      tests_failed++; $display("FAIL br_lu_cnt got flush=%0d stall=%0d exp %0d/%0d",
                               flush_count, stall_cycles, exp_flush, exp_stall);
    end
  endtask

  task automatic test_fetch_discard();
    set_idle();
    imem_ready = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_FETCH) begin
      tests_failed++; $display("FAIL t4_wait1 got=%b exp=%b", ctrl, C_FETCH);
    end
    tick(); exp_stall++;
    ex_branch_taken = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_BRANCH) begin
      tests_failed++; $display("FAIL t4_branch got=%b exp=%b", ctrl, C_BRANCH);
    end
    tick(); exp_flush++;
    // Stale word arrives: dropped.
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_FETCH) begin
      tests_failed++; $display("FAIL t4_discard got=%b exp=%b", ctrl, C_FETCH);
    end
    tick(); exp_stall++;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL t4_back_to_run got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
    tests_run++;
    if (stall_cycles !== CNT_W'(exp_stall) || flush_count !== CNT_W'(exp_flush)) begin
      tests_failed++; $display("FAIL t4_cnt got stall=%0d flush=%0d exp %0d/%0d",
                               stall_cycles, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic test_dstall();
    set_idle();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ctrl !== C_DSTALL) begin
        tests_failed++; $display("FAIL t5_frozen%0d got=%b exp=%b", i, ctrl, C_DSTALL);
      end
      tick(); exp_stall++;
    end
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_BRANCH) begin
      tests_failed++; $display("FAIL t5_release got=%b exp=%b", ctrl, C_BRANCH);
    end
    tick(); exp_flush++;
    set_idle();
    tests_run++;
    if (stall_cycles !== CNT_W'(exp_stall) || flush_count !== CNT_W'(exp_flush)) begin
      tests_failed++; $display("FAIL t5_cnt got stall=%0d flush=%0d exp %0d/%0d",
                               stall_cycles, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic test_saturate_reset();
    int need;
    need = 32'hFFFE - exp_stall;
    set_idle();
    mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (need) tick();
    tests_run++;
    if (stall_cycles !== 16'hFFFE) begin
      tests_failed++; $display("FAIL t6_pre_sat got=%h exp=fffe", stall_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (stall_cycles !== 16'hFFFF) begin
        tests_failed++; $display("FAIL t6_sat%0d got=%h exp=ffff", i, stall_cycles);
      end
    end
    // Enter DISCARD: fetch wait, then a branch while the fetch is still out.
    set_idle();
    imem_ready = 1'b0;
    tick();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_FETCH) begin
      tests_failed++; $display("FAIL t6_in_discard got=%b exp=%b", ctrl, C_FETCH);
    end
    // Asynchronous reset mid-DISCARD.
    reset = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_RESET || stall_cycles !== '0 || flush_count !== '0) begin
      tests_failed++; $display("FAIL t6_async_reset got ctrl=%b stall=%0d flush=%0d exp %b/0/0",
                               ctrl, stall_cycles, flush_count, C_RESET);
    end
    tick();
    reset = 1'b0;
    imem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL t6_run_after_reset got=%b exp=%b", ctrl, C_IDLE);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_fetch_discard();
    test_dstall();
    test_saturate_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
